// File: rtl/d_serial_tx_if.sv
// Handshake and serial-line bundle for d_serial_tx.
// The master drives the word and load request; the slave (transmitter) drives ready, D, busy and done.
interface d_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             D;
  logic             busy;
  logic             done;

  modport master (output din, load, input ready, D, busy, done);
  modport slave  (input din, load, output ready, D, busy, done);
endinterface

// File: rtl/d_serial_tx.sv
// LSB-first serial transmitter: start bit 0, WIDTH data bits, stop bit 1,
// each bit held DIV clocks. All outputs come straight from registers.
module d_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic          clk,
  input  logic          rst,
  d_serial_tx_if.slave  bus
);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int NXT   = (WIDTH > 1) ? 1 : 0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   sr_q;
  logic [DIV_W-1:0]   div_q;
  logic [BIT_W-1:0]   bit_q;
  logic               d_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               div_wrap;
  logic               bit_last;

  assign div_wrap = (div_q == DIV_W'(DIV - 1));
  assign bit_last = (bit_q == BIT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      d_q     <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            sr_q    <= bus.din;
            div_q   <= '0;
            bit_q   <= '0;
            d_q     <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (div_wrap) begin
            div_q   <= '0;
            d_q     <= sr_q[0];
            state_q <= DATA;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        DATA: begin
          if (div_wrap) begin
            div_q <= '0;
            sr_q  <= sr_q >> 1;
            bit_q <= bit_q + BIT_W'(1);
            // D is registered, so load the bit that follows the shift now
            if (bit_last) begin
              d_q     <= 1'b1;
              state_q <= STOP;
            end else begin
              d_q <= sr_q[NXT];
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        STOP: begin
          if (div_wrap) begin
            div_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.D     = d_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_d_serial_tx.sv
// Directed bench for d_serial_tx: main instance WIDTH=8/DIV=4, corner instance WIDTH=1/DIV=1.
module tb_d_serial_tx;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  d_serial_tx_if #(.WIDTH(8)) bus ();
  d_serial_tx_if #(.WIDTH(1)) bus1 ();

  d_serial_tx #(.WIDTH(8), .DIV(4)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  d_serial_tx #(.WIDTH(1), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected line level c cycles after the accepting edge of an 8-bit, DIV=4 frame.
  function automatic logic exp_d(input logic [7:0] data, input int c);
    int idx;
    idx = c / 4;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[idx-1];
    return 1'b1;
  endfunction

  // Waits (bounded) for ready, then presents one load; returns 1 ns after the accepting edge.
  task automatic do_load(input logic [7:0] d);
    int k;
    k = 0;
    while (bus.ready !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: ready=%b required 1", bus.ready);
    end
    bus.din  = d;
    bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.D, bus.ready, bus.busy, bus.done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_state: D/ready/busy/done=%b required 1100",
               {bus.D, bus.ready, bus.busy, bus.done});
    end
    $display("reset: D=%b ready=%b busy=%b done=%b", bus.D, bus.ready, bus.busy, bus.done);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [7:0] d;
    d = 8'hA5;
    do_load(d);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      checks++;
      if (bus.D !== exp_d(d, c) || bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL a5_cycle%0d: D=%b ready=%b busy=%b done=%b required D=%b ready=0 busy=1 done=0",
                 c, bus.D, bus.ready, bus.busy, bus.done, exp_d(d, c));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.D !== 1'b1) begin
      errors++;
      $display("FAIL a5_done: done=%b ready=%b busy=%b D=%b required 1 1 0 1",
               bus.done, bus.ready, bus.busy, bus.D);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL a5_done_width: done=%b required 0", bus.done);
    end
    $display("single frame 0xA5 sent");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    d = 8'h00;
    do_load(d);
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 40; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        checks++;
        if (bus.D !== exp_d(d, c) || bus.ready !== 1'b0 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_f%0d_cycle%0d: D=%b ready=%b done=%b required D=%b ready=0 done=0",
                   f, c, bus.D, bus.ready, bus.done, exp_d(d, c));
        end
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b1 || bus.D !== 1'b1 || bus.ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_f%0d_done: done=%b D=%b ready=%b required 1 1 1",
                 f, bus.done, bus.D, bus.ready);
      end
      if (f == 0) begin
        // Load during the done cycle: accepted at the very next edge
        d = 8'hFF;
        bus.din  = d;
        bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
      end
    end
    $display("back-to-back 0x00,0xFF sent");
  endtask

  task automatic test_ignored_load();
    logic [7:0] d;
    d = 8'h81;
    do_load(d);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 10) begin
        bus.din  = 8'h3C;
        bus.load = 1'b1;
      end
      if (c == 11) bus.load = 1'b0;
      checks++;
      if (bus.D !== exp_d(d, c) || bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL ign_cycle%0d: D=%b ready=%b required D=%b ready=0",
                 c, bus.D, bus.ready, exp_d(d, c));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL ign_done: done=%b required 1", bus.done);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.D !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1) begin
        errors++;
        $display("FAIL ign_idle%0d: D=%b busy=%b done=%b ready=%b required 1 0 0 1",
                 c, bus.D, bus.busy, bus.done, bus.ready);
      end
    end
    $display("ignored load: 0x81 frame intact, no follow-on frame");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    do_load(8'hC3);
    for (int c = 1; c <= 17; c++) begin @(posedge clk); #1; end
    // Now inside data bit 3; assert reset between edges
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.D !== 1'b1 || bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: D=%b busy=%b ready=%b done=%b required 1 0 1 0",
               bus.D, bus.busy, bus.ready, bus.done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.D !== 1'b1) begin
        errors++;
        $display("FAIL midrst_quiet%0d: done=%b D=%b required 0 1", c, bus.done, bus.D);
      end
    end
    d = 8'h5A;
    do_load(d);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      checks++;
      if (bus.D !== exp_d(d, c)) begin
        errors++;
        $display("FAIL r5a_cycle%0d: D=%b required %b", c, bus.D, exp_d(d, c));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL r5a_done: done=%b required 1", bus.done);
    end
    $display("reset mid-frame: line released, 0x5A frame sent after recovery");
  endtask

  task automatic test_corner_w1_d1();
    logic [2:0] exp_seq;
    exp_seq = 3'b110;   // bit c is D on cycle c: 0,1,1
    checks++;
    if (bus1.ready !== 1'b1) begin
      errors++;
      $display("FAIL w1_ready: ready=%b required 1", bus1.ready);
    end
    bus1.din  = 1'b1;
    bus1.load = 1'b1;
    @(posedge clk); #1;
    bus1.load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      checks++;
      if (bus1.D !== exp_seq[c] || bus1.done !== 1'b0 || bus1.busy !== 1'b1) begin
        errors++;
        $display("FAIL w1_cycle%0d: D=%b done=%b busy=%b required D=%b done=0 busy=1",
                 c, bus1.D, bus1.done, bus1.busy, exp_seq[c]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus1.done !== 1'b1 || bus1.D !== 1'b1 || bus1.ready !== 1'b1) begin
      errors++;
      $display("FAIL w1_done: done=%b D=%b ready=%b required 1 1 1", bus1.done, bus1.D, bus1.ready);
    end
    $display("corner WIDTH=1 DIV=1 frame sent");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    bus.din   = '0;
    bus.load  = 1'b0;
    bus1.din  = '0;
    bus1.load = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_frame();
    test_corner_w1_d1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
